// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 mux.
// Requests are double-flop synchronized; a grant may be preempted after QUANTUM cycles.
module mux_rr_arbiter #(
   parameter int unsigned QUANTUM = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   input  logic data_a,
   input  logic data_b,
   output logic grant_a,
   output logic grant_b,
   output logic sel,
   output logic out_mux,
   output logic switch_pulse
);

   localparam int unsigned CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam logic [CW-1:0] CntMax = CW'(QUANTUM - 1);

   typedef enum logic [1:0] {StIdle, StGntA, StGntB} state_e;

   logic [1:0]    r_sync_a;
   logic [1:0]    r_sync_b;
   logic          w_ra;
   logic          w_rb;
   state_e        r_state;
   state_e        w_state_d;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_d;
   logic          w_sat;
   logic          r_last_a;
   logic          w_last_a_d;
   logic          r_sel;
   logic          w_sel_d;
   logic          r_switch;
   logic          w_switch_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync_a <= 2'b00;
         r_sync_b <= 2'b00;
      end else begin
         r_sync_a <= {r_sync_a[0], req_a};
         r_sync_b <= {r_sync_b[0], req_b};
      end
   end

   assign w_ra  = r_sync_a[1];
   assign w_rb  = r_sync_b[1];
   assign w_sat = (r_cnt == CntMax);

   always_comb begin
      w_state_d  = r_state;
      w_cnt_d    = r_cnt;
      w_last_a_d = r_last_a;
      w_sel_d    = r_sel;
      w_switch_d = 1'b0;

      unique case (r_state)
         StIdle: begin
            if (w_ra && w_rb) begin
               w_state_d = r_last_a ? StGntB : StGntA;
            end else if (w_ra) begin
               w_state_d = StGntA;
            end else if (w_rb) begin
               w_state_d = StGntB;
            end
         end
         StGntA: begin
            // Release outranks preempt; both hand over to B when it is requesting.
            if (!w_ra) begin
               w_state_d = w_rb ? StGntB : StIdle;
            end else if (w_sat && w_rb) begin
               w_state_d = StGntB;
            end
         end
         StGntB: begin
            if (!w_rb) begin
               w_state_d = w_ra ? StGntA : StIdle;
            end else if (w_sat && w_ra) begin
               w_state_d = StGntA;
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_state_d != r_state) begin
         if (w_state_d == StGntA) begin
            w_cnt_d    = '0;
            w_last_a_d = 1'b1;
            w_sel_d    = 1'b1;
            w_switch_d = (r_state == StGntB);
         end else if (w_state_d == StGntB) begin
            w_cnt_d    = '0;
            w_last_a_d = 1'b0;
            w_sel_d    = 1'b0;
            w_switch_d = (r_state == StGntA);
         end
      end else if (r_state != StIdle && !w_sat) begin
         w_cnt_d = r_cnt + 1'b1;
      end
   end

   // sel keeps its last value through IDLE so the mux select never glitches on release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= '0;
         r_last_a <= 1'b0;
         r_sel    <= 1'b0;
         r_switch <= 1'b0;
      end else begin
         r_state  <= w_state_d;
         r_cnt    <= w_cnt_d;
         r_last_a <= w_last_a_d;
         r_sel    <= w_sel_d;
         r_switch <= w_switch_d;
      end
   end

   assign grant_a      = (r_state == StGntA);
   assign grant_b      = (r_state == StGntB);
   assign sel          = r_sel;
   assign switch_pulse = r_switch;

   always_comb begin
      out_mux = 1'b0;
      if (r_state == StGntA) begin
         out_mux = data_a;
      end else if (r_state == StGntB) begin
         out_mux = data_b;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench: vector table on a QUANTUM=4 instance, hand sequences for reset
// and a QUANTUM=1 instance for strict alternation and mutual exclusion.
module tb_mux_rr_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   logic req_a, req_b, data_a, data_b;
   logic grant_a, grant_b, sel, out_mux, switch_pulse;
   logic q1_req_a, q1_req_b, q1_data_a, q1_data_b;
   logic q1_grant_a, q1_grant_b, q1_sel, q1_out_mux, q1_switch_pulse;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.QUANTUM(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_a        (req_a),
      .req_b        (req_b),
      .data_a       (data_a),
      .data_b       (data_b),
      .grant_a      (grant_a),
      .grant_b      (grant_b),
      .sel          (sel),
      .out_mux      (out_mux),
      .switch_pulse (switch_pulse)
   );

   mux_rr_arbiter #(.QUANTUM(1)) u_dut_q1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_a        (q1_req_a),
      .req_b        (q1_req_b),
      .data_a       (q1_data_a),
      .data_b       (q1_data_b),
      .grant_a      (q1_grant_a),
      .grant_b      (q1_grant_b),
      .sel          (q1_sel),
      .out_mux      (q1_out_mux),
      .switch_pulse (q1_switch_pulse)
   );

   typedef struct {
      logic        ra, rb, da, db;
      int unsigned n;
      logic        ga, gb, sl, om, sw;
   } vec_t;

   vec_t vecs [18];

   task automatic check(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic ga, input logic gb, input logic sl,
                            input logic om, input logic sw);
      check({tag, ".grant_a"}, grant_a, ga);
      check({tag, ".grant_b"}, grant_b, gb);
      check({tag, ".sel"}, sel, sl);
      check({tag, ".out_mux"}, out_mux, om);
      check({tag, ".switch_pulse"}, switch_pulse, sw);
   endtask

   initial begin
      // Inputs are driven 1 time unit after the edge; edge 1 is the first to sample them.
      //          ra    rb    da    db    n   ga    gb    sel   out   sw
      vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; data_a = 1'b1; data_b = 1'b1;
      q1_req_a = 1'b0; q1_req_b = 1'b0; q1_data_a = 1'b0; q1_data_b = 1'b0;
      tick(2);
      check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         req_a  = vecs[i].ra;
         req_b  = vecs[i].rb;
         data_a = vecs[i].da;
         data_b = vecs[i].db;
         tick(vecs[i].n);
         check_all($sformatf("vec%0d", i), vecs[i].ga, vecs[i].gb, vecs[i].sl, vecs[i].om,
                   vecs[i].sw);
      end

      // Reset mid-grant while both request, then tie must go to A three edges later.
      req_a = 1'b1;
      tick(1);
      check("pre_rst.grant_b", grant_b, 1'b1);
      rst_n = 1'b0;
      tick(1);
      check_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n  = 1'b1;
      data_a = 1'b1;
      tick(2);
      check("post_rst_e2.grant_a", grant_a, 1'b0);
      check("post_rst_e2.grant_b", grant_b, 1'b0);
      tick(1);
      check_all("post_rst_e3", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // QUANTUM = 1: strict alternation with continuous switch_pulse.
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      q1_req_a = 1'b1; q1_req_b = 1'b1; q1_data_a = 1'b1; q1_data_b = 1'b0;
      tick(3);
      check("q1_first.grant_a", q1_grant_a, 1'b1);
      check("q1_first.switch_pulse", q1_switch_pulse, 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check($sformatf("q1_alt%0d.grant_a", i), q1_grant_a, (i % 2) == 1);
         check($sformatf("q1_alt%0d.grant_b", i), q1_grant_b, (i % 2) == 0);
         check($sformatf("q1_alt%0d.sel", i), q1_sel, (i % 2) == 1);
         check($sformatf("q1_alt%0d.out_mux", i), q1_out_mux, (i % 2) == 1);
         check($sformatf("q1_alt%0d.switch_pulse", i), q1_switch_pulse, 1'b1);
      end

      for (int i = 0; i < 1000; i++) begin
         q1_req_a  = 1'($urandom_range(1));
         q1_req_b  = 1'($urandom_range(1));
         q1_data_a = 1'($urandom_range(1));
         q1_data_b = 1'($urandom_range(1));
         tick(1);
         check("rand.exclusive", q1_grant_a & q1_grant_b, 1'b0);
         check("rand.out_mux", q1_out_mux,
               q1_grant_a ? q1_data_a : (q1_grant_b ? q1_data_b : 1'b0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
